// File: rtl/tx_manchester_encoder_pkg.sv
// Shared types, timing defaults and the per-tick modulation helper for the
// 106 kbit/s PICC->PCD Manchester encoder.
package tx_manchester_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOC  = 2'd1,
        DATA = 2'd2,
        EOC  = 2'd3
    } tx_state_e;

    // fc ticks per bit period (must be even) and subcarrier period in ticks.
    localparam int DEFAULT_TICKS_PER_BIT  = 128;
    localparam int DEFAULT_SUBCARRIER_DIV = 16;

    // Modulation level at one tick of a bit period. A '1' modulates the first
    // half, a '0' the second half. Each subcarrier period starts high.
    function automatic logic bit_pattern(
        input logic b,
        input int   tick,
        input int   ticks_per_bit = DEFAULT_TICKS_PER_BIT,
        input int   sc_div        = DEFAULT_SUBCARRIER_DIV
    );
        logic sc;
        logic first_half;
        sc         = (tick % sc_div) < (sc_div / 2);
        first_half = tick < (ticks_per_bit / 2);
        return b ? (sc && first_half) : (sc && !first_half);
    endfunction

endpackage

// File: rtl/tx_manchester_encoder_if.sv
// Bit-stream handshake between the framing logic and the encoder.
// Handshake: a bit moves on every rising clk edge where in_valid && in_ready.
// in_data/in_last are only meaningful while in_valid is high. The source may
// raise in_valid at any time; in_ready is computed from encoder state only
// and never depends on in_valid.
interface tx_manchester_encoder_if;
    logic in_valid;
    logic in_data;
    logic in_last;
    logic in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/tx_manchester_encoder_bit_timer.sv
// Bit-period tick counter. Counts 0..TICKS_PER_BIT-1 while run is high,
// returns to 0 when idle, and can be forced back to tick 0 by restart.
// next_tick is exported so the owner can register outputs aligned to the
// tick value that becomes current on the next edge.
module tx_manchester_encoder_bit_timer #(
    parameter  int TICKS_PER_BIT = 128,
    localparam int TW            = $clog2(TICKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          restart,
    output logic [TW-1:0] next_tick,
    output logic          boundary
);

    logic [TW-1:0] tick;

    assign boundary = (tick == TW'(TICKS_PER_BIT - 1));

    // Next tick: restart or idle go to 0, otherwise increment and wrap.
    always_comb begin
        next_tick = '0;
        if (!restart && run && !boundary) begin
            next_tick = tick + TW'(1);
        end
    end

    // Tick register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= '0;
        end else begin
            tick <= next_tick;
        end
    end

endmodule

// File: rtl/tx_manchester_encoder.sv
// PICC->PCD 106 kbit/s bit encoder: SOC, Manchester data on an fc/16
// subcarrier, then EOC. tx_out is registered and always equals the pattern
// for the current (state, tick, bit), so it starts on the edge that enters
// SOC and drops on the edge that enters EOC or IDLE.
module tx_manchester_encoder
    import tx_manchester_encoder_pkg::*;
#(
    parameter int TICKS_PER_BIT  = DEFAULT_TICKS_PER_BIT,
    parameter int SUBCARRIER_DIV = DEFAULT_SUBCARRIER_DIV
) (
    input  logic                          clk,
    input  logic                          rst_n,
    tx_manchester_encoder_if.slave        bits,
    input  logic                          abort,
    output logic                          tx_out,
    output logic                          busy,
    output logic                          underflow,
    output tx_state_e                     state
);

    localparam int TW = $clog2(TICKS_PER_BIT);

    tx_state_e     state_q, state_n;
    logic          cur_bit, cur_bit_n;
    logic          last_seen, last_seen_n;
    logic          underflow_n;
    logic          tx_out_n;
    logic          restart;
    logic          run;
    logic          boundary;
    logic          xfer;
    logic [TW-1:0] next_tick;

    tx_manchester_encoder_bit_timer #(
        .TICKS_PER_BIT(TICKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .restart  (restart),
        .next_tick(next_tick),
        .boundary (boundary)
    );

    assign run   = (state_q != IDLE);
    assign busy  = (state_q != IDLE);
    assign state = state_q;

    // A bit is only taken at the end of SOC or a data bit, never after the
    // last bit, and never on an abort edge.
    assign bits.in_ready = ((state_q == SOC) || (state_q == DATA)) && boundary
                           && !last_seen && !abort;
    assign xfer = bits.in_valid && bits.in_ready;

    // Next-state logic: frame sequencing, bit capture, abort and underflow.
    always_comb begin
        state_n     = state_q;
        cur_bit_n   = cur_bit;
        last_seen_n = last_seen;
        underflow_n = 1'b0;
        restart     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bits.in_valid) begin
                    // Start does not consume a bit; SOC uses the '1' pattern.
                    state_n     = SOC;
                    restart     = 1'b1;
                    cur_bit_n   = 1'b1;
                    last_seen_n = 1'b0;
                end
            end
            SOC, DATA: begin
                if (abort) begin
                    state_n = EOC;
                    restart = 1'b1;
                end else if (boundary) begin
                    if (last_seen) begin
                        state_n = EOC;
                    end else if (xfer) begin
                        state_n     = DATA;
                        cur_bit_n   = bits.in_data;
                        last_seen_n = bits.in_last;
                    end else begin
                        // Source starved: close the partial frame.
                        state_n     = EOC;
                        underflow_n = 1'b1;
                    end
                end
            end
            EOC: begin
                if (boundary) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Modulation value for the tick that becomes current on the next edge.
    always_comb begin
        tx_out_n = 1'b0;
        if ((state_n == SOC) || (state_n == DATA)) begin
            tx_out_n = bit_pattern(cur_bit_n, 32'(next_tick), TICKS_PER_BIT, SUBCARRIER_DIV);
        end
    end

    // State, bit registers and registered load-modulator drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_bit   <= 1'b0;
            last_seen <= 1'b0;
            underflow <= 1'b0;
            tx_out    <= 1'b0;
        end else begin
            state_q   <= state_n;
            cur_bit   <= cur_bit_n;
            last_seen <= last_seen_n;
            underflow <= underflow_n;
            tx_out    <= tx_out_n;
        end
    end

endmodule

// File: tb/tb_tx_manchester_encoder.sv
// Directed bench for tx_manchester_encoder: a queue-fed bit source, a sink
// that captures tx_out while busy and decodes it in 128-tick chunks, and an
// expected-symbol queue per frame.
module tb_tx_manchester_encoder;
    import tx_manchester_encoder_pkg::*;

    localparam int TPB = 128;
    localparam logic [1:0] SYM0    = 2'd0;
    localparam logic [1:0] SYM1    = 2'd1;
    localparam logic [1:0] SYM_EOC = 2'd2;
    localparam logic [1:0] SYM_BAD = 2'd3;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      abort;
    logic      tx_out;
    logic      busy;
    logic      underflow;
    tx_state_e state;

    tx_manchester_encoder_if bits();

    tx_manchester_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bits     (bits),
        .abort    (abort),
        .tx_out   (tx_out),
        .busy     (busy),
        .underflow(underflow),
        .state    (state)
    );

    // clock
    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [1:0] src_q[$];   // {last, data}
    logic [1:0] exp_q[$];   // expected symbols of the captured frame(s)
    logic       cap[$];     // tx_out per busy cycle
    logic       rdy_cap[$]; // in_ready per busy cycle
    int         uf_cnt    = 0;
    int         cyc       = 0;
    int         last_fall = -1;
    int         gap       = -1;
    bit         busy_s    = 1'b0;
    bit         busy_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference modulation level, written from the waveform definition.
    function automatic logic ref_level(input logic [1:0] sym, input int t);
        logic sc;
        sc = ((t % 16) < 8);
        case (sym)
            SYM1:    return sc && (t < 64);
            SYM0:    return sc && (t >= 64);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] decode(input int base);
        bit m1 = 1'b1;
        bit m0 = 1'b1;
        bit me = 1'b1;
        if (base + TPB > cap.size()) return SYM_BAD;
        for (int t = 0; t < TPB; t++) begin
            if (cap[base + t] !== ref_level(SYM1, t))    m1 = 1'b0;
            if (cap[base + t] !== ref_level(SYM0, t))    m0 = 1'b0;
            if (cap[base + t] !== ref_level(SYM_EOC, t)) me = 1'b0;
        end
        return m1 ? SYM1 : (m0 ? SYM0 : (me ? SYM_EOC : SYM_BAD));
    endfunction

    function automatic int count_ones(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (i < cap.size() && cap[i] === 1'b1) n++;
        return n;
    endfunction

    task automatic drive_src();
        bits.in_valid = (src_q.size() > 0);
        bits.in_data  = (src_q.size() > 0) ? src_q[0][0] : 1'b0;
        bits.in_last  = (src_q.size() > 0) ? src_q[0][1] : 1'b0;
    endtask

    // One clock: sample at negedge, advance source after the rising edge.
    task automatic cycle();
        bit fire;
        @(negedge clk);
        cyc++;
        fire   = bits.in_valid && bits.in_ready;
        busy_s = busy;
        if (busy) begin
            cap.push_back(tx_out);
            rdy_cap.push_back(bits.in_ready);
        end
        if (underflow) uf_cnt++;
        if (busy && !busy_prev && last_fall >= 0) gap = cyc - last_fall;
        if (!busy && busy_prev) last_fall = cyc;
        busy_prev = busy;
        @(posedge clk);
        #1;
        if (fire) void'(src_q.pop_front());
        drive_src();
    endtask

    // Queue n bits of word, MSB first; optionally mark the final one last.
    task automatic push_bits(input logic [31:0] word, input int n, input bit mark_last);
        for (int i = n - 1; i >= 0; i--) src_q.push_back({mark_last && (i == 0), word[i]});
        drive_src();
    endtask

    task automatic expect_frame(input logic [31:0] word, input int n);
        exp_q.push_back(SYM1);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(word[i] ? SYM1 : SYM0);
        exp_q.push_back(SYM_EOC);
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        bit started = 1'b0;
        while (n < budget && !(started && !busy_s)) begin
            cycle();
            if (busy_s) started = 1'b1;
            n++;
        end
        check({tag, "_done"}, 32'(started && !busy_s), 32'(1));
    endtask

    task automatic wait_index(input string tag, input int idx);
        int n = 0;
        while (cap.size() < idx && n < 4000) begin
            cycle();
            n++;
        end
        check({tag, "_reach"}, cap.size(), idx);
    endtask

    task automatic check_capture(input string tag, input int exp_len);
        check({tag, "_len"}, cap.size(), exp_len);
        foreach (exp_q[k]) check($sformatf("%s_sym%0d", tag, k), 32'(decode(k * TPB)), 32'(exp_q[k]));
        cap.delete();
        rdy_cap.delete();
        exp_q.delete();
    endtask

    initial begin
        int mis;
        rst_n = 1'b0;
        abort = 1'b0;
        drive_src();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_out", 32'(tx_out), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_in_ready", 32'(bits.in_ready), 32'(0));
        check("rst_underflow", 32'(underflow), 32'(0));
        check("rst_state", 32'(state), 32'(IDLE));
        rst_n = 1'b1;
        repeat (2) cycle();

        // 1: bits 1,0,1,1
        push_bits(32'b1011, 4, 1'b1);
        expect_frame(32'b1011, 4);
        run_until_idle("t1", 2000);
        check("t1_rdy_126", 32'(rdy_cap[126]), 32'(0));
        check("t1_rdy_127", 32'(rdy_cap[127]), 32'(1));
        check("t1_consumed", src_q.size(), 0);
        check("t1_underflow", uf_cnt, 0);
        check_capture("t1", 6 * TPB);

        // 2: a single 0 with in_last
        push_bits(32'b0, 1, 1'b1);
        expect_frame(32'b0, 1);
        run_until_idle("t2", 1000);
        check("t2_hi_64_71", count_ones(TPB + 64, TPB + 71), 8);
        check("t2_lo_72_79", count_ones(TPB + 72, TPB + 79), 0);
        check_capture("t2", 3 * TPB);

        // 3: source has only 2 of 8 bits ready, then stalls
        uf_cnt = 0;
        push_bits(32'b10, 2, 1'b0);
        expect_frame(32'b10, 2);
        run_until_idle("t3", 1500);
        check("t3_underflow", uf_cnt, 1);
        check("t3_state", 32'(state), 32'(IDLE));
        check_capture("t3", 4 * TPB);

        // 4: abort at tick 40 of data bit 2 (a '1'), bits 3-4 held
        uf_cnt = 0;
        push_bits(32'b0101, 4, 1'b1);
        wait_index("t4", 2 * TPB + 40);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("t4_held", src_q.size(), 2);
        src_q.delete();
        drive_src();
        run_until_idle("t4", 1000);
        mis = 0;
        for (int t = 0; t <= 40; t++) if (cap[2 * TPB + t] !== ref_level(SYM1, t)) mis++;
        check("t4_partial_bit", mis, 0);
        check("t4_eoc_zero", count_ones(2 * TPB + 41, 2 * TPB + 41 + TPB - 1), 0);
        check("t4_underflow", uf_cnt, 0);
        exp_q.push_back(SYM1);
        exp_q.push_back(SYM0);
        check_capture("t4", 2 * TPB + 41 + TPB);

        // 4b: abort on the SOC boundary with a bit offered
        push_bits(32'b11, 2, 1'b1);
        wait_index("t4b", TPB - 1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("t4b_rdy", 32'(rdy_cap[TPB - 1]), 32'(0));
        check("t4b_held", src_q.size(), 2);
        src_q.delete();
        drive_src();
        run_until_idle("t4b", 1000);
        exp_q.push_back(SYM1);
        exp_q.push_back(SYM_EOC);
        check_capture("t4b", 2 * TPB);

        // 5: reset at tick 20 of SOC, then a fresh 0xA5 frame
        push_bits(32'h5, 4, 1'b1);
        wait_index("t5", 20);
        rst_n = 1'b0;
        #1;
        check("t5_tx_out", 32'(tx_out), 32'(0));
        check("t5_busy", 32'(busy), 32'(0));
        check("t5_in_ready", 32'(bits.in_ready), 32'(0));
        src_q.delete();
        drive_src();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cap.delete();
        rdy_cap.delete();
        busy_prev = 1'b0;
        cycle();
        push_bits(32'hA5, 8, 1'b1);
        expect_frame(32'hA5, 8);
        run_until_idle("t5", 2000);
        check_capture("t5", 10 * TPB);

        // 6: two frames back to back with in_valid held
        gap = -1;
        push_bits(32'h3C, 8, 1'b1);
        push_bits(32'hC3, 8, 1'b1);
        expect_frame(32'h3C, 8);
        expect_frame(32'hC3, 8);
        run_until_idle("t6a", 3000);
        run_until_idle("t6b", 3000);
        check("t6_gap", gap, 1);
        check_capture("t6", 20 * TPB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
